clock_step_controller: RTL and testbench

- Debug clock scheduler that sits between the board clock/reset generator and the CPU design.
- Produces a clock-enable (ce) and a timed, PLL-lock-qualified design reset (resetn).
- The design runs free-running, halted, single/multi-stepped, or at a programmable 1/2^k rate, all without gating or deriving clocks.
- A host (UART debug bridge or buttons) issues commands over a valid/ready interface.

---
 rtl/clock_step_controller.sv | 173 +++++++++++++++++
 tb/tb_clock_step_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_controller.sv
// Debug clock scheduler: lock-qualified design reset plus a registered clock-enable
// for free-run, halt, N-step and 1/2^k slow modes; the clock itself is never gated.
module clock_step_controller #(
  parameter int RESET_CYCLES = 4095,
  parameter bit START_HALTED = 1'b0,
  parameter int DIV_W        = 5,
  parameter int STEP_W       = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        pll_locked,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  output logic        resetn,
  output logic        ce,
  output logic        busy,
  output logic [2:0]  state,
  output logic [31:0] ce_count
);

  typedef enum logic [2:0] {
    S_RST_WAIT = 3'd0,
    S_RUN      = 3'd1,
    S_HALT     = 3'd2,
    S_STEP     = 3'd3,
    S_SLOW     = 3'd4
  } state_e;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_SLOW = 2'b11;

  localparam int LOCK_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(RESET_CYCLES - 1);
  // Divider wide enough for the largest exponent the k field can express.
  localparam int DIVC_W = (1 << DIV_W) - 1;

  state_e              state_q, state_d;
  logic                resetn_q, resetn_d;
  logic                ce_q, ce_d;
  logic                busy_q, busy_d;
  logic [31:0]         ce_count_q, ce_count_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [DIVC_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]    slow_k_q, slow_k_d;

  logic [STEP_W-1:0]   step_n;
  logic [DIVC_W-1:0]   div_inc;
  logic [DIVC_W-1:0]   slow_mask;
  logic                unused_arg;

  assign step_n     = cmd_arg[STEP_W-1:0];
  assign div_inc    = div_cnt_q + DIVC_W'(1);
  assign slow_mask  = ~({DIVC_W{1'b1}} << slow_k_q);
  assign unused_arg = ^cmd_arg;

  assign cmd_ready = pll_locked && (state_q != S_RST_WAIT);

  always_comb begin
    state_d    = state_q;
    resetn_d   = resetn_q;
    ce_d       = ce_q;
    busy_d     = busy_q;
    lock_cnt_d = lock_cnt_q;
    step_cnt_d = step_cnt_q;
    div_cnt_d  = div_cnt_q;
    slow_k_d   = slow_k_q;
    ce_count_d = ce_q ? ce_count_q + 32'd1 : ce_count_q;

    if (state_q == S_RST_WAIT) begin
      if (!pll_locked) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LOCK_LAST) begin
        lock_cnt_d = '0;
        resetn_d   = 1'b1;
        state_d    = START_HALTED ? S_HALT : S_RUN;
        ce_d       = !START_HALTED;
      end else begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
    end else if (!pll_locked) begin
      // Lock loss outranks any command presented on the same edge.
      state_d    = S_RST_WAIT;
      resetn_d   = 1'b0;
      ce_d       = 1'b0;
      busy_d     = 1'b0;
      lock_cnt_d = '0;
      step_cnt_d = '0;
      div_cnt_d  = '0;
      ce_count_d = '0;
    end else if (cmd_valid) begin
      step_cnt_d = '0;
      div_cnt_d  = '0;
      unique case (cmd_op)
        OP_RUN: begin
          state_d = S_RUN;
          ce_d    = 1'b1;
          busy_d  = 1'b0;
        end
        OP_HALT: begin
          state_d = S_HALT;
          ce_d    = 1'b0;
          busy_d  = 1'b0;
        end
        OP_STEP: begin
          state_d    = S_STEP;
          ce_d       = 1'b1;
          busy_d     = 1'b1;
          step_cnt_d = (step_n == '0) ? '0 : step_n - STEP_W'(1);
        end
        OP_SLOW: begin
          state_d  = S_SLOW;
          ce_d     = 1'b1;
          busy_d   = 1'b0;
          slow_k_d = cmd_arg[DIV_W-1:0];
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        S_STEP: begin
          if (step_cnt_q == '0) begin
            state_d = S_HALT;
            ce_d    = 1'b0;
            busy_d  = 1'b0;
          end else begin
            step_cnt_d = step_cnt_q - STEP_W'(1);
          end
        end
        S_SLOW: begin
          div_cnt_d = div_inc;
          ce_d      = ((div_inc & slow_mask) == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_RST_WAIT;
      resetn_q   <= 1'b0;
      ce_q       <= 1'b0;
      busy_q     <= 1'b0;
      ce_count_q <= '0;
      lock_cnt_q <= '0;
      step_cnt_q <= '0;
      div_cnt_q  <= '0;
      slow_k_q   <= '0;
    end else begin
      state_q    <= state_d;
      resetn_q   <= resetn_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
      ce_count_q <= ce_count_d;
      lock_cnt_q <= lock_cnt_d;
      step_cnt_q <= step_cnt_d;
      div_cnt_q  <= div_cnt_d;
      slow_k_q   <= slow_k_d;
    end
  end

  assign resetn   = resetn_q;
  assign ce       = ce_q;
  assign busy     = busy_q;
  assign state    = state_q;
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Scoreboard bench: stimulus predicts every ce pulse (cycle, state, busy, ce_count);
// a negedge monitor pops one prediction per observed pulse.
module tb_clock_step_controller;

  localparam int ST_RST  = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;
  localparam int ST_STEP = 3;
  localparam int ST_SLOW = 4;

  logic        CLK;
  logic        RESET;
  logic        pll_locked;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        resetn;
  logic        ce;
  logic        busy;
  logic [2:0]  state;
  logic [31:0] ce_count;

  clock_step_controller #(
    .RESET_CYCLES(16),
    .START_HALTED(1'b0),
    .DIV_W(5),
    .STEP_W(16)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .pll_locked(pll_locked),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .resetn(resetn),
    .ce(ce),
    .busy(busy),
    .state(state),
    .ce_count(ce_count)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic        bsy;
    logic [31:0] cnt;
  } pulse_t;

  pulse_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     exp_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every cycle with ce=1 must match the oldest outstanding prediction.
  always @(negedge CLK) begin
    pulse_t e;
    if (ce === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: at cyc=%0d saw ce=1 state=%0d, required no pulse", cyc, state);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || state !== e.st || busy !== e.bsy || ce_count !== e.cnt) begin
          bad++;
          $display("FAIL pulse: got cyc=%0d state=%0d busy=%0b ce_count=%0d, required cyc=%0d state=%0d busy=%0b ce_count=%0d",
                   cyc, state, busy, ce_count, e.cyc, e.st, e.bsy, e.cnt);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, total=%0d", total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int c, input int st, input logic b);
    pulse_t p;
    p.cyc = c;
    p.st  = 3'(st);
    p.bsy = b;
    p.cnt = 32'(exp_cnt);
    exp_q.push_back(p);
    exp_cnt++;
  endtask

  task automatic push_run(input int first, input int n, input int st, input logic b);
    for (int i = 0; i < n; i++) push(first + i, st, b);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // Called just after a negedge; the command is accepted on the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    #1 chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  int r, t0, a, acc, acc2, acc3, acc4, acc5;

  initial begin
    RESET      = 1'b1;
    pll_locked = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_arg    = 16'd0;
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_resetn", {31'd0, resetn}, 32'd0);
    chk("rst_ce", {31'd0, ce}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {29'd0, state}, ST_RST);
    chk("rst_ce_count", ce_count, 32'd0);

    // Lock glitch at lock count 10; resetn 16 edges after relock.
    RESET = 1'b1;
    r = cyc;
    wait_to(r + 10);
    pll_locked = 1'b0;
    wait_to(r + 11);
    pll_locked = 1'b1;
    wait_to(r + 26);
    chk("glitch_resetn_early", {31'd0, resetn}, 32'd0);
    t0 = r + 27;
    push_run(t0, 5, ST_RUN, 1'b0);
    wait_to(t0);
    chk("glitch_resetn_rise", {31'd0, resetn}, 32'd1);
    chk("glitch_state", {29'd0, state}, ST_RUN);

    // Lock loss in RUN beats a simultaneous command.
    wait_to(t0 + 4);
    pll_locked = 1'b0;
    cmd_valid  = 1'b1;
    cmd_op     = 2'b01;
    #1 chk("lockloss_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("lockloss_resetn", {31'd0, resetn}, 32'd0);
    chk("lockloss_ce", {31'd0, ce}, 32'd0);
    chk("lockloss_state", {29'd0, state}, ST_RST);
    chk("lockloss_ce_count", ce_count, 32'd0);
    exp_cnt = 0;

    // Clean relock: resetn and ce rise on the 16th locked edge.
    pll_locked = 1'b1;
    r = cyc;
    wait_to(r + 15);
    chk("relock_resetn_early", {31'd0, resetn}, 32'd0);
    push_run(r + 16, 5, ST_RUN, 1'b0);
    wait_to(r + 16);
    chk("relock_resetn", {31'd0, resetn}, 32'd1);
    chk("relock_ce_count", ce_count, 32'd0);

    // HALT, then STEP 3 and STEP 0.
    wait_to(r + 20);
    issue(2'b01, 16'd0);
    a = cyc;
    exp_cnt = exp_cnt;
    chk("halt_ce", {31'd0, ce}, 32'd0);
    chk("halt_state", {29'd0, state}, ST_HALT);
    acc = cyc + 1;
    push_run(acc, 3, ST_STEP, 1'b1);
    issue(2'b10, 16'd3);
    wait_to(acc + 3);
    chk("step3_state", {29'd0, state}, ST_HALT);
    chk("step3_busy", {31'd0, busy}, 32'd0);
    chk("step3_ce_count", ce_count, 32'(exp_cnt));
    acc = cyc + 1;
    push(acc, ST_STEP, 1'b1);
    issue(2'b10, 16'd0);
    wait_to(acc + 1);
    chk("step0_state", {29'd0, state}, ST_HALT);
    chk("step0_ce", {31'd0, ce}, 32'd0);

    // SLOW 2: pulses on cycles 1, 5, 9, 13 after accept; then SLOW 0 continuous.
    acc = cyc + 1;
    push(acc, ST_SLOW, 1'b0);
    push(acc + 4, ST_SLOW, 1'b0);
    push(acc + 8, ST_SLOW, 1'b0);
    push(acc + 12, ST_SLOW, 1'b0);
    issue(2'b11, 16'd2);
    wait_to(acc + 14);
    acc2 = cyc + 1;
    push_run(acc2, 6, ST_SLOW, 1'b0);
    issue(2'b11, 16'd0);

    // STEP 100 cut short by RUN after 10 pulses: no gap, busy drops at once.
    wait_to(acc2 + 5);
    acc3 = cyc + 1;
    push_run(acc3, 10, ST_STEP, 1'b1);
    issue(2'b10, 16'd100);
    wait_to(acc3 + 9);
    acc4 = cyc + 1;
    push_run(acc4, 5, ST_RUN, 1'b0);
    issue(2'b00, 16'd0);

    // STEP 60, async reset with 50 steps left.
    wait_to(acc4 + 4);
    acc5 = cyc + 1;
    push_run(acc5, 10, ST_STEP, 1'b1);
    issue(2'b10, 16'd60);
    wait_to(acc5 + 9);
    #2 RESET = 1'b0;
    #1;
    chk("async_resetn", {31'd0, resetn}, 32'd0);
    chk("async_ce", {31'd0, ce}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_state", {29'd0, state}, ST_RST);
    exp_cnt = 0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    r = cyc;
    wait_to(r + 15);
    chk("rerun_resetn_early", {31'd0, resetn}, 32'd0);
    push_run(r + 16, 5, ST_RUN, 1'b0);
    wait_to(r + 16);
    chk("rerun_resetn", {31'd0, resetn}, 32'd1);
    chk("rerun_state", {29'd0, state}, ST_RUN);
    wait_to(r + 20);
    issue(2'b01, 16'd0);
    repeat (3) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
